muldiv_unit: RTL and testbench

Multi-cycle RV32M multiply/divide unit in the execute stage, beside the single-cycle alu. It takes the same in1/in2 operand buses from the register-read/forwarding stage. Its result, negative and zero outputs feed the same writeback result mux as the alu. Flag semantics match the alu. Handshake is start/busy/done so the pipeline control stalls while it is busy.

---
 rtl/muldiv_unit_pkg.sv | 25 ++
 rtl/muldiv_unit_div_step.sv | 24 ++
 rtl/muldiv_unit.sv | 160 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 opcodes, iteration
// count and FSM state encoding.
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } muldiv_op_t;

  localparam int unsigned MULDIV_ITERS = 32;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder and keep the trial difference when it does not borrow.
module div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic            dbit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic            qbit
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // rem < divisor always holds, so bit XLEN of diff is exactly the borrow.
  always_comb begin
    shifted  = {rem, dbit};
    diff     = shifted - {1'b0, divisor};
    qbit     = ~diff[XLEN];
    rem_next = qbit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, with sign fix-up and start/busy/done handshake.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            negative,
  output logic            zero
);
  import muldiv_unit_pkg::*;

  localparam int unsigned CntW = $clog2(MULDIV_ITERS);
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t   state_q;
  muldiv_op_t      op_q;
  muldiv_op_t      op_in;
  logic [XLEN-1:0]   mcand_q;
  logic [2*XLEN-1:0] prod_q;
  logic [CntW-1:0]   cnt_q;
  logic              negq_q;
  logic              negr_q;
  logic              busy_q;
  logic              done_q;
  logic [XLEN-1:0]   result_q;

  logic              accept;
  logic              is_div;
  logic              sgn1;
  logic              sgn2;
  logic [XLEN-1:0]   abs1;
  logic [XLEN-1:0]   abs2;
  logic              div0;
  logic              ovf;
  logic [XLEN-1:0]   special_res;

  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   rem_next;
  logic              qbit;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   remd;
  logic [XLEN-1:0]   fix_res;

  always_comb begin
    op_in  = muldiv_op_t'(op);
    accept = start && (state_q == StIdle || state_q == StDone);
    is_div = op[2];
    sgn1   = in1[XLEN-1] && (op_in inside {OpMulh, OpMulhsu, OpDiv, OpRem});
    sgn2   = in2[XLEN-1] && (op_in inside {OpMulh, OpDiv, OpRem});
    abs1   = sgn1 ? -in1 : in1;
    abs2   = sgn2 ? -in2 : in2;
    div0   = is_div && (in2 == '0);
    ovf    = (op_in inside {OpDiv, OpRem}) && (in1 == MinNeg) && (in2 == '1);
    // op[1] distinguishes REM/REMU from DIV/DIVU
    if (div0) begin
      special_res = op[1] ? in1 : '1;
    end else begin
      special_res = op[1] ? '0 : MinNeg;
    end
  end

  div_step #(
    .XLEN(XLEN)
  ) u_div_step (
    .rem     (prod_q[2*XLEN-1:XLEN]),
    .dbit    (prod_q[XLEN-1]),
    .divisor (mcand_q),
    .rem_next(rem_next),
    .qbit    (qbit)
  );

  // prod_q holds {acc_hi, multiplier} for multiply and {remainder, dividend/quotient}
  // for divide; mcand_q holds the multiplicand or the divisor.
  always_comb begin
    mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_fix = negq_q ? -prod_q : prod_q;
    quot     = negq_q ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
    remd     = negr_q ? -prod_q[2*XLEN-1:XLEN] : prod_q[2*XLEN-1:XLEN];
    fix_res  = '0;
    unique case (op_q)
      OpMul:                      fix_res = prod_fix[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu:  fix_res = prod_fix[2*XLEN-1:XLEN];
      OpDiv, OpDivu:              fix_res = quot;
      OpRem, OpRemu:              fix_res = remd;
      default:                    fix_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= OpMul;
      mcand_q  <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        op_q    <= op_in;
        negq_q  <= sgn1 ^ sgn2;
        negr_q  <= sgn1;
        cnt_q   <= '0;
        mcand_q <= is_div ? abs2 : abs1;
        prod_q  <= {{XLEN{1'b0}}, (is_div ? abs1 : abs2)};
        if (div0 || ovf) begin
          result_q <= special_res;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= StDone;
        end else begin
          busy_q  <= 1'b1;
          state_q <= StCalc;
        end
      end else begin
        case (state_q)
          StCalc: begin
            if (op_q[2]) begin
              prod_q <= {rem_next, prod_q[XLEN-2:0], qbit};
            end else begin
              prod_q <= {mul_sum, prod_q[XLEN-1:1]};
            end
            cnt_q <= cnt_q + CntW'(1);
            if (cnt_q == CntW'(MULDIV_ITERS - 1)) begin
              state_q <= StFix;
            end
          end
          StFix: begin
            result_q <= fix_res;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= StDone;
          end
          StDone: state_q <= StIdle;
          default: ;
        endcase
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign negative = result_q[XLEN-1];
  assign zero     = (result_q == '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors push expected results, a negedge
// monitor pops and checks them whenever done is seen.
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        negative;
  logic        zero;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          t0;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[$];

  muldiv_unit #(
    .XLEN(32)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .in1     (in1),
    .in2     (in2),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .negative(negative),
    .zero    (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=done expected=no_done result=%h", result);
      end else begin
        mon_e = sb.pop_front();
        check("result", result, mon_e.res);
        check("negative", {31'b0, negative}, {31'b0, mon_e.res[31]});
        check("zero", {31'b0, zero}, {31'b0, (mon_e.res == 32'h0)});
        check("latency", 32'(cyc - mon_e.t0), 32'(mon_e.lat));
      end
    end
  end

  // Called at a negedge; start is sampled at the following posedge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input bit push);
    exp_t e;
    op    = o;
    in1   = a;
    in2   = b;
    start = 1'b1;
    if (push) begin
      e.res = exp;
      e.lat = lat;
      e.t0  = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    op    = 3'b101;
    in1   = 32'hDEADBEEF;
    in2   = 32'h0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || sb.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL timeout actual=pending expected=idle outstanding=%0d", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    start = 1'b0;
    op    = 3'b000;
    in1   = 32'h0;
    in2   = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);
    check("reset_result", result, 32'h0);
    check("reset_negative", {31'b0, negative}, 32'h0);
    check("reset_zero", {31'b0, zero}, 32'h1);
    reset = 1'b0;
    @(negedge clk);

    // MUL with busy length and done width
    issue(3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 34, 1'b1);
    n = 0;
    while (busy && n < 60) begin
      n++;
      @(negedge clk);
    end
    check("busy_cycles", 32'(n), 32'd33);
    check("done_at_busy_fall", {31'b0, done}, 32'h1);
    @(negedge clk);
    check("done_width", {31'b0, done}, 32'h0);
    wait_idle();
    @(negedge clk);

    vecs.push_back('{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34});
    vecs.push_back('{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34});
    vecs.push_back('{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34});
    vecs.push_back('{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34});
    vecs.push_back('{3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34});
    vecs.push_back('{3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34});
    vecs.push_back('{3'b101, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 34});
    vecs.push_back('{3'b111, 32'hFFFFFFF9, 32'd2, 32'h00000001, 34});
    vecs.push_back('{3'b110, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 34});
    vecs.push_back('{3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34});
    vecs.push_back('{3'b100, 32'd5, 32'd0, 32'hFFFFFFFF, 1});
    vecs.push_back('{3'b111, 32'd5, 32'd0, 32'h00000005, 1});
    vecs.push_back('{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
    vecs.push_back('{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1});
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, 1'b1);
      wait_idle();
      @(negedge clk);
    end

    // start while busy is ignored
    issue(3'b000, 32'd3, 32'd4, 32'd12, 34, 1'b1);
    repeat (4) @(negedge clk);
    issue(3'b000, 32'd100, 32'd100, 32'd0, 0, 1'b0);
    wait_idle();
    repeat (40) @(negedge clk);
    check("ignored_start_result", result, 32'd12);

    // reset mid-operation aborts with no done
    issue(3'b000, 32'd9, 32'd9, 32'd0, 0, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_done", {31'b0, done}, 32'h0);
    check("abort_result", result, 32'h0);
    check("abort_zero", {31'b0, zero}, 32'h1);
    reset = 1'b0;
    repeat (45) @(negedge clk);

    // back-to-back start in the DONE cycle
    issue(3'b000, 32'd6, 32'd7, 32'd42, 34, 1'b1);
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      checks++;
      failures++;
      $display("FAIL b2b_first_done actual=none expected=done");
    end
    issue(3'b101, 32'd100, 32'd7, 32'd14, 34, 1'b1);
    wait_idle();
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
